// File: rtl/rom_cache_pkg.sv
// Shared types and address-split helpers for the ROM line cache.
// Helpers work on a widened address so one set serves any width.
package rom_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_DONE
    } state_e;

    function automatic logic [63:0] addr_off(
        input logic [63:0] a,
        input int          lw
    );
        return a & ((64'd1 << lw) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_idx(
        input logic [63:0] a,
        input int          lw,
        input int          iw
    );
        return (a >> lw) & ((64'd1 << iw) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(
        input logic [63:0] a,
        input int          lw,
        input int          iw
    );
        return a >> (lw + iw);
    endfunction

endpackage

// File: rtl/cache_ram_dp.sv
// Simple dual-port RAM: write on port A, registered read on port B.
// Contents are not reset; the valid bits gate any stale entries.
module cache_ram_dp #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/rom_line_cache.sv
// Direct-mapped read-only line cache between a CPU ROM fetch port and
// the SDRAM ROM channel; critical-word-first fills, one-cycle flush.
module rom_line_cache
    import rom_cache_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8,
    parameter int LINE_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cache_req,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic              flush,
    output logic              cache_valid,
    output logic [DATA_W-1:0] cache_data,
    output logic              hit,
    output logic              busy,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_valid
);

    localparam int TAG_W   = ADDR_W - IDX_W - LINE_W;
    localparam int OFF_W   = (LINE_W > 0) ? LINE_W : 1;
    localparam int OFF_PAD = OFF_W - LINE_W;
    localparam int DA_W    = IDX_W + LINE_W;
    localparam int NLINES  = 1 << IDX_W;
    localparam int NBEATS  = 1 << LINE_W;

    state_e              state_q, state_d;
    logic [NLINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
    logic [OFF_W-1:0]    crit_q, crit_d;
    logic [OFF_W-1:0]    beat_q, beat_d;
    logic                flushed_q, flushed_d;
    logic                cache_valid_q, cache_valid_d;
    logic [DATA_W-1:0]   cache_data_q, cache_data_d;
    logic                hit_q, hit_d;
    logic                rom_req_q, rom_req_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;

    logic [TAG_W-1:0]    lk_tag;
    logic [IDX_W-1:0]    lk_idx;
    logic [OFF_W-1:0]    lk_off;
    logic [OFF_W-1:0]    fill_off;
    logic [ADDR_W-1:0]   fill_addr;
    logic [DA_W-1:0]     data_waddr;
    logic [DATA_W-1:0]   data_rdata;
    logic [TAG_W-1:0]    tag_rdata;
    logic                data_we, tag_we;
    logic                lk_hit, last_beat;

    assign lk_tag = TAG_W'(addr_tag(64'(cache_addr), LINE_W, IDX_W));
    assign lk_idx = IDX_W'(addr_idx(64'(cache_addr), LINE_W, IDX_W));
    assign lk_off = OFF_W'(addr_off(64'(cache_addr), LINE_W));

    // Offset arithmetic wraps inside the line, never into the index.
    assign fill_off   = crit_q + beat_q;
    assign fill_addr  = ADDR_W'({fill_tag_q, fill_idx_q, fill_off} >> OFF_PAD);
    assign data_waddr = DA_W'({fill_idx_q, fill_off} >> OFF_PAD);
    assign last_beat  = (beat_q == OFF_W'(NBEATS - 1));
    assign lk_hit     = valid_q[lk_idx] && (tag_rdata == lk_tag);

    cache_ram_dp #(.AW(DA_W), .DW(DATA_W)) u_data_ram (
        .clk     (clk),
        .we_i    (data_we),
        .waddr_i (data_waddr),
        .wdata_i (rom_data),
        .raddr_i (DA_W'(cache_addr)),
        .rdata_o (data_rdata)
    );

    cache_ram_dp #(.AW(IDX_W), .DW(TAG_W)) u_tag_ram (
        .clk     (clk),
        .we_i    (tag_we),
        .waddr_i (fill_idx_q),
        .wdata_i (fill_tag_q),
        .raddr_i (lk_idx),
        .rdata_o (tag_rdata)
    );

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        fill_tag_d    = fill_tag_q;
        fill_idx_d    = fill_idx_q;
        crit_d        = crit_q;
        beat_d        = beat_q;
        flushed_d     = flushed_q;
        cache_valid_d = cache_valid_q & cache_req;
        cache_data_d  = cache_data_q;
        hit_d         = 1'b0;
        rom_req_d     = rom_req_q;
        rom_addr_d    = rom_addr_q;
        data_we       = 1'b0;
        tag_we        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cache_req) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!cache_req) begin
                    state_d = S_IDLE;
                end else if (lk_hit) begin
                    cache_data_d  = data_rdata;
                    cache_valid_d = 1'b1;
                    hit_d         = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    fill_tag_d = lk_tag;
                    fill_idx_d = lk_idx;
                    crit_d     = lk_off;
                    beat_d     = '0;
                    flushed_d  = 1'b0;
                    state_d    = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                rom_req_d  = 1'b1;
                rom_addr_d = fill_addr;
                state_d    = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (rom_valid) begin
                    rom_req_d = 1'b0;
                    data_we   = 1'b1;
                    if (beat_q == '0 && cache_req) begin
                        cache_data_d  = rom_data;
                        cache_valid_d = 1'b1;
                    end
                    if (last_beat) begin
                        tag_we = 1'b1;
                        if (!flushed_q && !flush) begin
                            valid_d[fill_idx_q] = 1'b1;
                        end
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_FILL_REQ;
                    end
                end
            end
            S_DONE: begin
                // Also leave when nothing was delivered to this request.
                if (!cache_req || !cache_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush && (state_q == S_FILL_REQ || state_q == S_FILL_WAIT)) begin
            flushed_d = 1'b1;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            valid_q       <= '0;
            fill_tag_q    <= '0;
            fill_idx_q    <= '0;
            crit_q        <= '0;
            beat_q        <= '0;
            flushed_q     <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_data_q  <= '0;
            hit_q         <= 1'b0;
            rom_req_q     <= 1'b0;
            rom_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            fill_tag_q    <= fill_tag_d;
            fill_idx_q    <= fill_idx_d;
            crit_q        <= crit_d;
            beat_q        <= beat_d;
            flushed_q     <= flushed_d;
            cache_valid_q <= cache_valid_d;
            cache_data_q  <= cache_data_d;
            hit_q         <= hit_d;
            rom_req_q     <= rom_req_d;
            rom_addr_q    <= rom_addr_d;
        end
    end

    assign cache_valid = cache_valid_q;
    assign cache_data  = cache_data_q;
    assign hit         = hit_q;
    assign busy        = (state_q == S_FILL_REQ) || (state_q == S_FILL_WAIT);
    assign rom_req     = rom_req_q;
    assign rom_addr    = rom_addr_q;

endmodule

// File: tb/tb_rom_line_cache.sv
// Scoreboard bench for rom_line_cache with a behavioural SDRAM responder.
// Expected words are queued at request time and popped on cache_valid.
module tb_rom_line_cache;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cache_req;
    logic [22:0] cache_addr;
    logic        flush;
    logic        cache_valid;
    logic [15:0] cache_data;
    logic        hit;
    logic        busy;
    logic        rom_req;
    logic [22:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_valid;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    int wait_c = 0;
    int req_cycles = 0;
    bit stray_req = 0;
    logic [15:0] exp_q [$];
    logic [22:0] addr_log [$];

    rom_line_cache dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cache_req   (cache_req),
        .cache_addr  (cache_addr),
        .flush       (flush),
        .cache_valid (cache_valid),
        .cache_data  (cache_data),
        .hit         (hit),
        .busy        (busy),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rom_valid   (rom_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [22:0] a);
        return a[15:0] ^ 16'h5A3C ^ {a[22:16], 9'h000};
    endfunction

    // SDRAM: answers a held rom_req after 'lat' extra cycles.
    initial begin
        rom_valid = 1'b0;
        rom_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rom_valid = 1'b0;
                wait_c = 0;
            end else if (rom_valid) begin
                rom_valid = 1'b0;
            end else if (stray_req) begin
                rom_valid = 1'b1;
                rom_data  = 16'hDEAD;
                stray_req = 0;
            end else if (rom_req) begin
                if (wait_c >= lat) begin
                    rom_valid = 1'b1;
                    rom_data  = model(rom_addr);
                    addr_log.push_back(rom_addr);
                    wait_c = 0;
                end else begin
                    wait_c++;
                end
            end else begin
                wait_c = 0;
            end
            if (rom_req) req_cycles++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || cache_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || cache_valid) begin
            $display("FAIL idle_timeout: busy=%0b valid=%0b, required 0/0",
                     busy, cache_valid);
            errors++;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [22:0] a, input bit exp_hit);
        int lat_c = 0;
        int rq0 = req_cycles;
        logic [15:0] exp;
        exp_q.push_back(model(a));
        cache_addr = a;
        cache_req  = 1'b1;
        while (!cache_valid && lat_c < 300) begin
            @(negedge clk);
            lat_c++;
        end
        checks++;
        if (!cache_valid) begin
            $display("FAIL fetch_timeout %h: valid=0, required 1", a);
            errors++;
            void'(exp_q.pop_front());
        end else begin
            exp = exp_q.pop_front();
            if (cache_data !== exp) begin
                $display("FAIL data %h: got %h, required %h", a, cache_data, exp);
                errors++;
            end
            checks++;
            if (hit !== exp_hit) begin
                $display("FAIL hit %h: got %b, required %b", a, hit, exp_hit);
                errors++;
            end
            if (exp_hit) begin
                checks++;
                if (lat_c != 2) begin
                    $display("FAIL hit_latency %h: got %0d, required 2", a, lat_c);
                    errors++;
                end
            end
            @(negedge clk);
            checks++;
            if (cache_valid !== 1'b1 || hit !== 1'b0 || cache_data !== exp) begin
                $display("FAIL valid_hold %h: valid=%b hit=%b data=%h, required 1 0 %h",
                         a, cache_valid, hit, cache_data, exp);
                errors++;
            end
        end
        cache_req = 1'b0;
        wait_idle();
        if (exp_hit) begin
            checks++;
            if (req_cycles != rq0) begin
                $display("FAIL hit_rom_req %h: got %0d req cycles, required 0",
                         a, req_cycles - rq0);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cache_req = 1'b0;
        cache_addr = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cache_valid, cache_data, hit, busy, rom_req, rom_addr} !== '0) begin
            $display("FAIL reset_outputs: v=%b d=%h h=%b b=%b r=%b a=%h, required 0",
                     cache_valid, cache_data, hit, busy, rom_req, rom_addr);
            errors++;
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cold_miss();
        logic [22:0] exp_seq [4] = '{23'h105, 23'h106, 23'h107, 23'h104};
        lat = 0;
        addr_log.delete();
        fetch(23'h000105, 1'b0);
        checks++;
        if (addr_log.size() != 4) begin
            $display("FAIL beat_count: got %0d, required 4", addr_log.size());
            errors++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[i] !== exp_seq[i]) begin
                    $display("FAIL beat_addr%0d: got %h, required %h",
                             i, addr_log[i], exp_seq[i]);
                    errors++;
                end
            end
        end
        fetch(23'h000104, 1'b1);
        fetch(23'h000107, 1'b1);
    endtask

    task automatic test_conflict();
        lat = 2;
        fetch(23'h010105, 1'b0);
        fetch(23'h010106, 1'b1);
        fetch(23'h000105, 1'b0);
        fetch(23'h000106, 1'b1);
    endtask

    task automatic test_flush();
        int n = 0;
        lat = 1;
        addr_log.delete();
        exp_q.push_back(model(23'h200));
        cache_addr = 23'h200;
        cache_req  = 1'b1;
        while (!(addr_log.size() == 2 && rom_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (addr_log.size() != 2 || !rom_req || !cache_valid) begin
            $display("FAIL flush_setup: beats=%0d req=%b valid=%b, required 2 1 1",
                     addr_log.size(), rom_req, cache_valid);
            errors++;
            void'(exp_q.pop_front());
        end else begin
            checks++;
            if (cache_data !== exp_q[0]) begin
                $display("FAIL flush_crit_data: got %h, required %h",
                         cache_data, exp_q[0]);
                errors++;
            end
            void'(exp_q.pop_front());
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cache_req = 1'b0;
        wait_idle();
        checks++;
        if (addr_log.size() != 4) begin
            $display("FAIL flush_fill_done: got %0d beats, required 4",
                     addr_log.size());
            errors++;
        end
        fetch(23'h000203, 1'b0);
        fetch(23'h000201, 1'b1);
    endtask

    task automatic test_reset_midfill();
        int n = 0;
        lat = 3;
        fetch(23'h000300, 1'b0);
        fetch(23'h000301, 1'b1);
        exp_q.push_back(model(23'h305));
        cache_addr = 23'h305;
        cache_req  = 1'b1;
        while (!cache_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cache_valid || cache_data !== exp_q[0]) begin
            $display("FAIL midfill_crit: valid=%b data=%h, required 1 %h",
                     cache_valid, cache_data, exp_q[0]);
            errors++;
        end
        void'(exp_q.pop_front());
        n = 0;
        while (!rom_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cache_valid, cache_data, hit, busy, rom_req, rom_addr} !== '0) begin
            $display("FAIL midfill_reset: v=%b d=%h h=%b b=%b r=%b a=%h, required 0",
                     cache_valid, cache_data, hit, busy, rom_req, rom_addr);
            errors++;
        end
        cache_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray_req = 1;
        repeat (4) @(negedge clk);
        checks++;
        if (cache_valid || busy || rom_req) begin
            $display("FAIL stray_beat: v=%b b=%b r=%b, required 0 0 0",
                     cache_valid, busy, rom_req);
            errors++;
        end
        fetch(23'h000300, 1'b0);
    endtask

    task automatic test_drop_req();
        int n = 0;
        int seen = 0;
        lat = 4;
        addr_log.delete();
        cache_addr = 23'h400;
        cache_req  = 1'b1;
        while (!rom_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        cache_req = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            if (cache_valid) seen++;
            @(negedge clk);
            n++;
        end
        repeat (2) begin
            if (cache_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL drop_valid: got %0d valid cycles, required 0", seen);
            errors++;
        end
        checks++;
        if (addr_log.size() != 4 || busy) begin
            $display("FAIL drop_fill: beats=%0d busy=%b, required 4 0",
                     addr_log.size(), busy);
            errors++;
        end
        fetch(23'h000402, 1'b1);
    endtask

    task automatic test_back_to_back();
        int rq0;
        logic [22:0] a;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            fetch(23'h500 + 23'(i * 4), 1'b0);
        end
        rq0 = req_cycles;
        for (int i = 0; i < 100; i++) begin
            a = 23'h500 + 23'($urandom_range(0, 15));
            fetch(a, 1'b1);
        end
        checks++;
        if (req_cycles != rq0) begin
            $display("FAIL b2b_rom_req: got %0d req cycles, required 0",
                     req_cycles - rq0);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_flush();
        test_reset_midfill();
        test_drop_req();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_left: got %0d entries, required 0",
                     exp_q.size());
            errors++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_line_cache.md
# rom_line_cache

Parametrised direct-mapped read-only cache between a CPU program-ROM fetch port (68k or Z80) and the shared SDRAM ROM channel. It generalises the single-word program-ROM cache to configurable address, data, index and line widths. Misses fill a whole line critical-word-first, and a `flush` input invalidates all lines in one cycle. One instance serves one CPU fetch port. The SDRAM arbiter sees it as an ordinary request/valid client.

## Interface
- `ADDR_W`, 23: word address width.
- `DATA_W`, 16: word width.
- `IDX_W`, 8: line index bits; the cache holds 2^IDX_W lines.
- `LINE_W`, 2: log2 words per line. 0 gives single-word lines.
- `TAG_W`, derived: `ADDR_W-IDX_W-LINE_W`. Not overridable.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `cache_req` in 1: fetch request. Held high with `cache_addr` stable until `cache_valid`.
- `cache_addr` in ADDR_W: word address of the fetch.
- `flush` in 1: one-cycle pulse that invalidates all lines.
- `cache_valid` out 1: `cache_data` is valid for the current request.
- `cache_data` out DATA_W: fetched word.
- `hit` out 1: one-cycle pulse, coincident with `cache_valid`, when the request was served from cache.
- `busy` out 1: high while a line fill is in progress.
- `rom_req` out 1: SDRAM beat request.
- `rom_addr` out ADDR_W: SDRAM word address for the current beat.
- `rom_data` in DATA_W: SDRAM read data.
- `rom_valid` in 1: one-cycle pulse; `rom_data` is valid for the current beat.

## Operation
- Address split: offset `[LINE_W-1:0]`, index `[LINE_W+:IDX_W]`, tag `[ADDR_W-1:LINE_W+IDX_W]`.
- Storage:
  - Data RAM: 2^(IDX_W+LINE_W) x DATA_W, one-cycle read latency.
  - Tag RAM: 2^IDX_W x TAG_W.
  - Valid bits: 2^IDX_W flip-flops, so flush and reset take one cycle.
- State machine: IDLE, LOOKUP, FILL_REQ, FILL_WAIT, DONE.
- IDLE:
  - `cache_req`=1 moves to LOOKUP.
  - The index and word address are driven to the RAM read ports in the same cycle.
- LOOKUP, hit (valid[index] and tag match):
  - Register `cache_data` from RAM; set `cache_valid`=1 and pulse `hit`.
  - Go to DONE.
- LOOKUP, miss:
  - Latch tag, index and critical offset; set beat counter to 0.
  - Go to FILL_REQ.
- FILL_REQ:
  - `rom_req`=1; `rom_addr` = {tag, index, (critical offset + beat) mod 2^LINE_W}.
  - Go to FILL_WAIT.
- FILL_WAIT:
  - `rom_req` stays high until `rom_valid`.
  - On `rom_valid`: write `rom_data` to the data RAM at {index, beat offset} and drop `rom_req` for at least one cycle.
  - Beat 0 (the critical word): load `cache_data` and assert `cache_valid`, provided `cache_req` is still high.
  - Last beat (beat = 2^LINE_W−1): write the tag, set the valid bit and go to DONE. Otherwise increment beat and return to FILL_REQ.
- DONE:
  - `cache_valid` holds while `cache_req` stays high.
  - When `cache_req`=0: clear `cache_valid` and go to IDLE.
  - If `cache_req` is still high after the fill (data already delivered on the critical beat), stay in DONE until it falls.
- Offset arithmetic wraps modulo 2^LINE_W inside the line and never carries into the index.

Boundary conditions:
- `cache_req` dropped during a fill: the fill still completes and the line becomes valid. `cache_valid` is not asserted for a critical beat that arrives after the drop.
- `flush` in any state: clears all valid bits next edge.
  - During a fill, the line being filled is not marked valid at its final beat.
  - `flush` and the final beat in the same cycle: flush wins.
- `flush` and a LOOKUP in the same cycle: the lookup reads pre-flush valid bits and a hit is served. Later requests miss.
- `reset_n` low at any time, including mid-fill:
  - All outputs go to 0 immediately: `cache_valid`, `cache_data`, `hit`, `busy`, `rom_req`, `rom_addr`.
  - All valid bits clear and the state returns to IDLE.
  - An SDRAM beat still pending when reset is released is ignored, because `rom_valid` is only honoured in FILL_WAIT.

## Timing
- Hit latency: 2 cycles from `cache_req` rising to `cache_valid` (IDLE, then LOOKUP, then valid).
- Miss latency: 2 cycles + SDRAM latency of beat 0. The remaining beats proceed after the data is delivered.
- Beat spacing: each beat has at least one idle `rom_req` cycle (rom_valid, then a low cycle, then the next request).
- `busy`: high from entering FILL_REQ to the final beat's write, inclusive.
- The next request is not accepted until the state returns to IDLE.

## Structure
- Shared package `rom_cache_pkg`:
  - State enum.
  - Helper functions for tag, index and offset extraction, parametrised by the widths.
- Sub-module `cache_ram_dp`: parametrised simple dual-port RAM (write port A, read port B, 1-cycle registered read).
  - Instantiated twice: data RAM and tag RAM.
  - Replaces fixed-size vendor RAMs.

## Test plan
All scenarios use the default parameters.
1. Cold miss at 0x000105:
   - `rom_addr` sequence 0x000105, 0x000106, 0x000107, 0x000104.
   - `cache_valid` on beat 0 with that beat's data.
   - A later request to 0x000104 hits with `hit`=1, latency 2 and no `rom_req`.
2. Conflict:
   - 0x000105 fills, then 0x010105 (same index 0x41, tag 0x40) misses and refills.
   - Re-requesting 0x000105 misses again.
3. `flush` pulsed during beat 2 of a fill: the fill finishes, then a request to the same line misses.
4. `reset_n` low during FILL_WAIT:
   - All outputs are 0 in the same cycle.
   - After release, a request to a previously filled address misses.
   - A stray `rom_valid` while IDLE is ignored.
5. `cache_req` dropped before beat 0 returns:
   - No `cache_valid` is asserted and the fill completes.
   - The next request to the same line hits.
6. 100 back-to-back hits across 4 valid lines: each returns the correct data at 2-cycle latency and `rom_req` stays 0 throughout.
